// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: strobe-in, valid/ready-out.
// Optional sticky overflow detection is compiled in with `define UART_RX_FIFO_OVF_EN.
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       wr_valid,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] rp;
    logic [CNT_W-1:0]  count_q;
    logic              push;
    logic              pop;

    assign full     = (count_q == FULL_COUNT);
    assign empty    = (count_q == '0);
    assign rd_valid = !empty;
    assign count    = count_q;
    assign rd_data  = mem[rp];

    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign pop  = rd_valid && rd_ready;
    assign push = wr_valid && (!full || pop);

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wp] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp      <= '0;
            rp      <= '0;
            count_q <= '0;
        end else if (clear) begin
            wp      <= '0;
            rp      <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wp <= wp + ADDR_W'(1);
            end
            if (pop) begin
                rp <= rp + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef UART_RX_FIFO_OVF_EN
    logic overflow_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (clear) begin
            overflow_q <= 1'b0;
        end else if (wr_valid && full && !pop) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;

    logic       clk;
    logic       reset;
    logic       clear;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic       ovf_m;
    logic [7:0] last_out;

    uart_rx_fifo #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .wr_data(wr_data), .wr_valid(wr_valid),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .count(count), .full(full), .empty(empty), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: every accepted head byte must match the oldest expected byte.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && !clear && rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", 32'(rd_data), 32'hFFFF_FFFF);
                end else begin
                    last_out = exp_q.pop_front();
                    chk("rd_data_pop", 32'(rd_data), 32'(last_out));
                end
            end
        end
    end

    task automatic check_state();
        int n;
        n = exp_q.size();
        chk("count", 32'(count), 32'(n));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("rd_valid", 32'(rd_valid), 32'(n > 0));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        if (n > 0) chk("rd_data_head", 32'(rd_data), 32'(exp_q[0]));
    endtask

    task automatic step(input logic wv, input logic [7:0] wd, input logic rr, input logic clr);
        int   n;
        logic pop_m;
        @(posedge clk);
        #1;
        check_state();
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        clear    = clr;
        n     = exp_q.size();
        pop_m = (n > 0) && rr;
        if (clr) begin
            exp_q.delete();
            ovf_m = 1'b0;
        end else if (wv) begin
            if (n < DEPTH || pop_m) exp_q.push_back(wd);
`ifdef UART_RX_FIFO_OVF_EN
            else ovf_m = 1'b1;
`endif
        end
    endtask

    task automatic idle_inputs();
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        clear    = 1'b0;
    endtask

    // Asserts reset between edges and checks the flags before the next edge.
    task automatic async_reset();
        @(posedge clk);
        #1;
        idle_inputs();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        exp_q.delete();
        ovf_m = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() > 0 && budget < 4 * DEPTH) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            budget++;
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        idle_inputs();
        ovf_m    = 1'b0;
        last_out = '0;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("init_count", 32'(count), 32'd0);
        chk("init_empty", 32'(empty), 32'd1);
        chk("init_full", 32'(full), 32'd0);
        reset = 1'b0;

        // Three bytes held, then released in order.
        step(1'b1, 8'h41, 1'b0, 1'b0);
        step(1'b1, 8'h42, 1'b0, 1'b0);
        step(1'b1, 8'h43, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t1_count", 32'(count), 32'd3);
        chk("t1_head", 32'(rd_data), 32'h41);
        drain();
        chk("t1_last", 32'(last_out), 32'h43);
        chk("t1_empty", 32'(empty), 32'd1);

        // Fill, then a dropped write while full.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t2_full", 32'(full), 32'd1);
`ifdef UART_RX_FIFO_OVF_EN
        chk("t2_overflow", 32'(overflow), 32'd1);
`else
        chk("t2_overflow", 32'(overflow), 32'd0);
`endif
        drain();
        chk("t2_last", 32'(last_out), 32'h0F);

        // Full FIFO with simultaneous push and pop.
        async_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t3_count", 32'(count), 32'd16);
        chk("t3_overflow", 32'(overflow), 32'd0);
        drain();
        chk("t3_last", 32'(last_out), 32'h55);

        // Streaming: one in, one out every cycle, pointers wrap.
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(8'h60 + i), 1'b1, 1'b0);
            if (i > 0) chk("t4_count", 32'(count), 32'd1);
        end
        drain();
        chk("t4_last", 32'(last_out), 32'h87);

        // Asynchronous reset with data held.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
        async_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Clear beats a concurrent write.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH - 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_overflow", 32'(overflow), 32'd0);
        step(1'b1, 8'h12, 1'b0, 1'b0);
        drain();
        chk("t5_last", 32'(last_out), 32'h12);

        // Randomized traffic with varying consumer stall rate and rare clears.
        for (int i = 0; i < 600; i++) begin
            int unsigned rr_pct;
            rr_pct = (i < 200) ? 20 : ((i < 400) ? 50 : 90);
            step($urandom_range(0, 99) < 70,
                 8'($urandom),
                 $urandom_range(0, 99) < rr_pct,
                 $urandom_range(0, 99) < 2);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer directly downstream of the UART receiver. It captures each byte the receiver presents with a one-cycle strobe and holds it in a circular FIFO. Bytes are handed to the consumer over a valid/ready interface. It decouples the fixed-rate serial byte arrival from a consumer that may stall, and reports occupancy and overrun.

## Interface
- `DATA_W`, 8, byte width; must match the receiver's data width.
- `DEPTH`, 16, FIFO entries; power of two, 2..256.
- `ADDR_W`, $clog2(DEPTH), pointer width; localparam, not overridable.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears pointers, count and flags.
- `clear`  in  1  synchronous flush; same effect as reset, one cycle.
- `wr_data`  in  DATA_W  byte from receiver.
- `wr_valid`  in  1  one-cycle strobe: `wr_data` is valid this cycle.
- `rd_data`  out  DATA_W  head-of-queue byte, valid when `rd_valid`.
- `rd_valid`  out  1  FIFO non-empty.
- `rd_ready`  in  1  consumer accepts head byte.
- `count`  out  ADDR_W+1  entries held, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky: a byte was dropped.

## Operation
- Storage: DEPTH x DATA_W register array, write pointer `wp`, read pointer `rp`, both ADDR_W bits, wrap modulo DEPTH naturally. `count` is a separate register.
- Push condition: `wr_valid && (!full || pop)`. On push: `mem[wp] <= wr_data`, `wp <= wp+1`.
- Pop condition: `rd_valid && rd_ready`. On pop: `rp <= rp+1`.
- `count` update: push only → +1; pop only → -1; both or neither → unchanged.
- Write while full without a same-cycle pop: byte discarded, pointers and count unchanged, `overflow` set (see Configuration).
- Simultaneous push and pop when full: both occur, count stays DEPTH, no overflow.
- Simultaneous push and pop when empty: pop impossible (`rd_valid`=0); push only.
- `rd_ready` while empty: ignored.
- `clear` has priority over push and pop in the same cycle. That cycle's `wr_valid` byte is discarded.
- Memory contents are not reset; only pointers, count and flags are.
- Reset values: `wp`=`rp`=0, `count`=0, `empty`=1, `full`=0, `rd_valid`=0, `overflow`=0. `rd_data` is don't-care while `rd_valid`=0.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Held data is lost.

## Timing
- `rd_data` = `mem[rp]`, combinational from registers; no output register.
- Write-to-read latency: a byte pushed on edge N is visible with `rd_valid`=1 after edge N. It can be popped at edge N+1.
- `count`, `full`, `empty`, `rd_valid` are registered or derived directly from registered `count`. All update on the edge where push/pop occurs.
- `rd_data` changes only after a pop, or after the first push into an empty FIFO.
- Full throughput: one push and one pop per cycle sustained indefinitely.
- `overflow` sets on the edge following the dropped write. It clears only on `reset` or `clear`.

## Configuration
- Macro `UART_RX_FIFO_OVF_EN`.
- Defined: overflow detection logic compiled in; `overflow` behaves as specified.
- Undefined: detection logic omitted; `overflow` tied to 0. Dropped-byte behaviour when full is unchanged: bytes are still discarded silently.

## Test plan
- Reset then push 0x41,0x42,0x43 with `rd_ready`=0 → `count`=3, `rd_valid`=1, `rd_data`=0x41. Raise `rd_ready` → 0x41,0x42,0x43 over 3 cycles, then `empty`=1.
- Push 16 bytes 0x00..0x0F, then push 0xAA with `rd_ready`=0 → `full`=1, `count`=16, `overflow`=1 (with macro), or 0 (without). Drain yields 0x00..0x0F; 0xAA is never read.
- Fill to 16, then push 0x55 and pop in the same cycle → `count` stays 16, `overflow`=0. Last byte out after draining is 0x55.
- Push and pop every cycle for 40 cycles with incrementing data → `count` constant at 1. Output sequence equals input sequence delayed 1 cycle; pointers wrap past 15 without error.
- Fill 5 bytes, assert `reset` asynchronously between clock edges → `count`=0, `empty`=1, `rd_valid`=0, `overflow`=0 before the next edge.
- Fill 5 bytes with `overflow` set, pulse `clear` together with `wr_valid`=1, `wr_data`=0x99 → next cycle `count`=0, `overflow`=0; 0x99 is not stored.
